// File: rtl/multicycle_adder.sv
// multicycle_adder: sequential add/subtract unit. Operands are summed CHUNK bits per
// cycle through a registered carry, so no combinational carry path exceeds CHUNK bits.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready high only in IDLE and out of reset
//   a, b, op_sub        operands; op_sub=1 computes a - b as a + ~b + 1
//   out_valid/out_ready result handshake
//   sum                 registered WIDTH-bit result
//   c_out               carry out of the MSB (for subtract: 1 = no borrow)
//   overflow            two's-complement overflow
//   zero                sum == 0
module multicycle_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (CHUNK == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("multicycle_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;
  logic              out_valid_q, out_valid_d;

  logic [CHUNK-1:0]  a_chunk, b_chunk;
  logic [CHUNK:0]    chunk_sum;
  logic              last_chunk;
  logic              msb_carry_in;

  assign a_chunk    = opa_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk    = opb_q[idx_q*CHUNK +: CHUNK];
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

  always_comb begin
    state_d      = state_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    acc_d        = acc_q;
    carry_d      = carry_q;
    idx_d        = idx_q;
    sum_d        = sum_q;
    c_out_d      = c_out_q;
    ovf_d        = ovf_q;
    zero_d       = zero_q;
    out_valid_d  = out_valid_q;
    msb_carry_in = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = op_sub ? ~b : b;
          carry_d = op_sub;
          idx_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        acc_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        carry_d = chunk_sum[CHUNK];
        idx_d   = idx_q + IDXW'(1);
        // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
        msb_carry_in = opa_q[WIDTH-1] ^ opb_q[WIDTH-1] ^ acc_d[WIDTH-1];
        if (last_chunk) begin
          sum_d       = acc_d;
          c_out_d     = chunk_sum[CHUNK];
          ovf_d       = msb_carry_in ^ chunk_sum[CHUNK];
          zero_d      = (acc_d == '0);
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      c_out_q     <= c_out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Gated by rst_n so in_ready is low while reset is held.
  assign in_ready  = (state_q == StIdle) && rst_n;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: one 8/4 instance and one default 32/8 instance, driven
// through a shared operand bus; cur_sel picks which instance sees the handshakes.
module tb_multicycle_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op_sub = 1'b0;
  logic        cur_sel = 1'b0;   // 0: 8/4 instance, 1: 32/8 instance

  logic        iv8, ir8, ov8, or8, c8, v8, z8;
  logic [7:0]  s8;
  logic        iv32, ir32, ov32, or32, c32, v32, z32;
  logic [31:0] s32;

  logic        sel_ir, sel_ov, sel_c, sel_v, sel_z;
  logic [31:0] sel_sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign iv8  = in_valid & ~cur_sel;
  assign iv32 = in_valid & cur_sel;
  assign or8  = out_ready & ~cur_sel;
  assign or32 = out_ready & cur_sel;

  assign sel_ir  = cur_sel ? ir32 : ir8;
  assign sel_ov  = cur_sel ? ov32 : ov8;
  assign sel_sum = cur_sel ? s32 : {24'h0, s8};
  assign sel_c   = cur_sel ? c32 : c8;
  assign sel_v   = cur_sel ? v32 : v8;
  assign sel_z   = cur_sel ? z32 : z8;

  multicycle_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a[7:0]), .b(b[7:0]),
    .op_sub(op_sub), .out_valid(ov8), .out_ready(or8), .sum(s8), .c_out(c8),
    .overflow(v8), .zero(z8)
  );

  multicycle_adder #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a), .b(b),
    .op_sub(op_sub), .out_valid(ov32), .out_ready(or32), .sum(s32), .c_out(c32),
    .overflow(v32), .zero(z32)
  );

  typedef struct {
    bit          sel;
    logic [31:0] a;
    logic [31:0] b;
    bit          sub;
    logic [31:0] sum;
    bit          c;
    bit          v;
    bit          z;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Handshake at edge E, then count edges until out_valid is seen (bounded).
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v, input bit sub,
                          output int lat);
    @(negedge clk);
    a = ta;
    b = tb_v;
    op_sub = sub;
    in_valid = 1'b1;
    chk("in_ready_before_op", {31'h0, sel_ir}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!sel_ov && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("ack_out_valid_low", {31'h0, sel_ov}, 32'd0);
    chk("ack_in_ready_high", {31'h0, sel_ir}, 32'd1);
  endtask

  task automatic chk_result(input string tag, input logic [31:0] es, input bit ec,
                            input bit ev, input bit ez);
    chk({tag, "_sum"}, sel_sum, es);
    chk({tag, "_c_out"}, {31'h0, sel_c}, {31'h0, ec});
    chk({tag, "_overflow"}, {31'h0, sel_v}, {31'h0, ev});
    chk({tag, "_zero"}, {31'h0, sel_z}, {31'h0, ez});
  endtask

  initial begin
    int lat;

    vecs[0] = '{0, 32'h7F,        32'h01,        0, 32'h80,        0, 1, 0};
    vecs[1] = '{0, 32'h05,        32'h05,        1, 32'h00,        1, 0, 1};
    vecs[2] = '{0, 32'h03,        32'h05,        1, 32'hFE,        0, 0, 0};
    vecs[3] = '{0, 32'h80,        32'h01,        1, 32'h7F,        1, 1, 0};
    vecs[4] = '{0, 32'hFF,        32'h01,        0, 32'h00,        1, 0, 1};
    vecs[5] = '{1, 32'hFFFF_FFFF, 32'h1,         0, 32'h0,         1, 0, 1};
    vecs[6] = '{1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'hACF1_3568, 0, 0, 0};
    vecs[7] = '{1, 32'h7FFF_FFFF, 32'h1,         0, 32'h8000_0000, 0, 1, 0};
    vecs[8] = '{1, 32'h0,         32'h1,         1, 32'hFFFF_FFFF, 0, 0, 0};
    vecs[9] = '{1, 32'h8000_0000, 32'h7FFF_FFFF, 1, 32'h1,         1, 1, 0};

    // Reset held with in_valid asserted on both instances.
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      cur_sel = s[0];
      #1;
      chk("rst_in_ready", {31'h0, sel_ir}, 32'd0);
      chk("rst_out_valid", {31'h0, sel_ov}, 32'd0);
      chk_result("rst", 32'h0, 0, 0, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready8", {31'h0, ir8}, 32'd1);
    chk("post_rst_in_ready32", {31'h0, ir32}, 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 10; i++) begin
      cur_sel = vecs[i].sel;
      start_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].sel ? 32'd4 : 32'd2);
      chk_result($sformatf("vec%0d", i), vecs[i].sum, vecs[i].c, vecs[i].v, vecs[i].z);
      ack_result();
    end

    // Backpressure on the 32/8 instance with a competing in_valid.
    cur_sel = 1'b1;
    start_op(32'h1, 32'h2, 0, lat);
    chk("bp_latency", lat, 32'd4);
    @(negedge clk);
    a = 32'h100;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid_held", {31'h0, sel_ov}, 32'd1);
      chk("bp_sum_held", sel_sum, 32'h3);
      chk("bp_in_ready_low", {31'h0, sel_ir}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", {31'h0, sel_ov}, 32'd0);
    chk("bp_release_in_ready", {31'h0, sel_ir}, 32'd1);
    chk("bp_idle_sum_holds", sel_sum, 32'h3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_new_accepted", {31'h0, sel_ir}, 32'd0);
    lat = 0;
    while (!sel_ov && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_new_latency", lat, 32'd4);
    chk("bp_new_sum", sel_sum, 32'h102);
    ack_result();

    // Reset during the second CALC cycle, then a fresh operation.
    @(negedge clk);
    a = 32'h0000_00FF;
    b = 32'h0000_0001;
    op_sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'h0, sel_ir}, 32'd0);
    chk("midrst_out_valid", {31'h0, sel_ov}, 32'd0);
    chk_result("midrst", 32'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'h8000_0000, 32'h8000_0000, 0, lat);
    chk("after_rst_latency", lat, 32'd4);
    chk_result("after_rst", 32'h0, 1, 1, 1);
    ack_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
